// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and mul/div EX occupancy.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_mul,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       ex_hold,
  output logic       mul_busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned PERF_W    = 32;
  localparam bit          MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;

  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("hazard_ctrl: MUL_LAT=%0d outside legal range 1..16", MUL_LAT);
  end

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;

  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next state and same-cycle hazard outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    mul_busy    = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_mul && MUL_MULTI) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      MUL_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ex_hold    = 1'b1;
        mul_busy   = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=4 main instance, MUL_LAT=1 companion).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_mul, ex_memread, ex_branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, mul_busy;
  logic       pc_write1, ifid_write1, ifid_flush1, idex_bubble1, ex_hold1, mul_busy1;
`ifdef HAZARD_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt1, perf_flush_cnt1;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mul(id_mul), .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold), .mul_busy(mul_busy)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  hazard_ctrl #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mul(id_mul), .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .ex_hold(ex_hold1), .mul_busy(mul_busy1)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt1), .perf_flush_cnt(perf_flush_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later
  task automatic drive(input logic br, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mul);
    @(negedge clk);
    ex_branch_taken = br;
    ex_memread      = mr;
    ex_rt           = ert;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    id_mul          = mul;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Bundle order: pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, mul_busy
  function automatic logic [31:0] outs();
    return 32'({pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, mul_busy});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ex_branch_taken = 1'b0; ex_memread = 1'b0; ex_rt = '0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_mul = 1'b0;
`ifdef HAZARD_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    #1;
    check("reset_outs", outs(), 32'b110000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle();
    check("idle_run", outs(), 32'b110000);

    // Load-use via rs, then cleared the next cycle
    drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    check("lu_rs_stall", outs(), 32'b000100);
    idle();
    check("lu_one_cycle", outs(), 32'b110000);

    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("lu_r0_nostall", outs(), 32'b110000);

    drive(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0);
    check("lu_rt_unused", outs(), 32'b110000);
    drive(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0);
    check("lu_rt_used", outs(), 32'b000100);

    // Load in EX without memread is no hazard
    drive(1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0);
    check("no_memread", outs(), 32'b110000);

    // Branch beats load-use and mul
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    check("branch_prio", outs(), 32'b111100);
    idle();
    check("branch_stay_run", outs(), 32'b110000);

    // Mul/div issue then 3 wait cycles (branch and lu ignored inside)
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("mul_issue", outs(), 32'b110000);
    check("mul1_issue_busy", 32'(mul_busy1), 32'd0);
    idle();
    check("mul_wait1", outs(), 32'b000011);
    check("mul1_wait1_busy", 32'(mul_busy1), 32'd0);
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    check("mul_wait2_ignore", outs(), 32'b000011);
    check("mul1_branch", 32'(ifid_flush1), 32'd1);
    idle();
    check("mul_wait3", outs(), 32'b000011);
    // Back-to-back: second mul on first RUN cycle
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("mul_b2b_issue", outs(), 32'b110000);
    idle();
    check("mul_b2b_wait1", outs(), 32'b000011);
    idle();
    check("mul_b2b_wait2", outs(), 32'b000011);
    idle();
    check("mul_b2b_wait3", outs(), 32'b000011);
    idle();
    check("mul_b2b_done", outs(), 32'b110000);

    // Reset aborts wait on its 2nd cycle
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle();
    check("rst_pre_wait1", outs(), 32'b000011);
    @(negedge clk);
    check("rst_pre_wait2", outs(), 32'b000011);
    #1 rst_n = 1'b0;
    #1;
    check("rst_abort", outs(), 32'b110000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("rst_mul_issue", outs(), 32'b110000);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_mul_wait", outs(), 32'b000011);
    end
    idle();
    check("rst_mul_done", outs(), 32'b110000);

`ifdef HAZARD_CTRL_PERF_EN
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    check("perf_clr_stall", perf_stall_cnt, 32'd0);
    check("perf_clr_flush", perf_flush_cnt, 32'd0);
    drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    check("perf_stall_cnt", perf_stall_cnt, 32'd4);
    check("perf_flush_cnt", perf_flush_cnt, 32'd1);
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    check("perf_clr2_stall", perf_stall_cnt, 32'd0);
    check("perf_clr2_flush", perf_flush_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and the PC and drives their write-enable and flush/bubble controls. It covers load-use stalls, taken-branch/jump flushes and multi-cycle multiply/divide occupancy of EX. A small FSM and down-counter hold the front end while a multi-cycle operation is in EX.

## Interface
- `MUL_LAT`, default 4: cycles a mul/div occupies EX; legal range 1..16.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  instruction in ID reads rt as a source.
- `id_mul`  in  1  instruction in ID is a multi-cycle mul/div.
- `ex_memread`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  destination register of the load in EX.
- `ex_branch_taken`  in  1  branch/jump in EX resolved taken; PC redirect this cycle.
- `pc_write`  out  1  1 = PC loads its next value.
- `ifid_write`  out  1  1 = IF/ID captures new data; 0 = hold.
- `ifid_flush`  out  1  1 = IF/ID loads zeros (NOP).
- `idex_bubble`  out  1  1 = ID/EX loads a NOP instead of the ID instruction.
- `ex_hold`  out  1  1 = ID/EX and the EX operand latches hold (mul/div in progress).
- `mul_busy`  out  1  FSM is in MUL_WAIT.

## Operation
- FSM states: RUN and MUL_WAIT. There is a 4-bit down-counter `cnt`.
- Outputs are combinational functions of the state and the current inputs, so hazards act in the same cycle they are detected.
- Load-use hazard (`lu`): `ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`.
- RUN priority, highest first:
  1. `ex_branch_taken`: `ifid_flush=1`, `idex_bubble=1`, `pc_write=1`, `ifid_write=1`. `id_mul` and `lu` are ignored. Stay in RUN.
  2. `lu`: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`. `id_mul` is ignored; the instruction retries next cycle. Stay in RUN.
  3. `id_mul`: normal advance (`pc_write=1`, `ifid_write=1`). If `MUL_LAT>1`, go to MUL_WAIT and set `cnt <= MUL_LAT-2`. If `MUL_LAT==1`, stay in RUN.
  4. Otherwise: `pc_write=1`, `ifid_write=1`, all other outputs 0.
- MUL_WAIT: `pc_write=0`, `ifid_write=0`, `ex_hold=1`, `mul_busy=1`, `idex_bubble=0`.
  - `ex_branch_taken` and `lu` are ignored, since EX holds the mul/div.
  - If `cnt==0`, go to RUN; otherwise decrement `cnt`.
- Reset (asynchronous, any time, including mid-MUL_WAIT): state=RUN, `cnt=0`. The wait is aborted immediately.
- Output values while `rst_n` is low (RUN with inputs low): `pc_write=1`, `ifid_write=1`, `ifid_flush=0`, `idex_bubble=0`, `ex_hold=0`, `mul_busy=0`.

## Timing
- Load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM and `lu` clears by construction.
- Branch flush lasts exactly 1 cycle and costs 2 squashed slots: IF/ID is flushed and ID/EX is bubbled.
- Mul/div: issue cycle in RUN is followed by `MUL_LAT-1` cycles in MUL_WAIT. The front end is held for `MUL_LAT-1` cycles in total.
- Back-to-back mul/div: a second `id_mul` seen on the first RUN cycle after MUL_WAIT re-enters MUL_WAIT with no gap cycle.
- Counter width is 4 bits. `MUL_LAT>16` is illegal: simulation `$error` at elaboration.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined adds the following ports:
  - `perf_clr` (in, 1): synchronous clear of both counters; takes priority over increment.
  - `perf_stall_cnt` (out, 32): increments on every cycle with `pc_write==0`.
  - `perf_flush_cnt` (out, 32): increments on every cycle with `ifid_flush==1`.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- `HAZARD_CTRL_PERF_EN` undefined: these ports and counters are absent. Control behaviour is identical either way.

## Test plan
- Load-use: `ex_memread=1`, `ex_rt=8`, `id_rs=8` → one cycle of `pc_write=0`, `ifid_write=0`, `idex_bubble=1`. Same stimulus with `ex_rt=0` → no stall.
- `id_uses_rt=0`, `id_rt=8`, `ex_rt=8`, `ex_memread=1` → no stall. Same with `id_uses_rt=1` → stall.
- `ex_branch_taken=1` together with `lu=1` and `id_mul=1` → `ifid_flush=1`, `idex_bubble=1`, `pc_write=1`; state stays RUN.
- `MUL_LAT=4`, `id_mul` pulse → `mul_busy`/`ex_hold` high for exactly 3 cycles, `pc_write=0` in those cycles, then RUN. With `MUL_LAT=1` → `mul_busy` never asserts.
- Assert `rst_n=0` on the 2nd MUL_WAIT cycle → `mul_busy=0` immediately, `pc_write=1`. After release, `id_mul` restarts a full 3-cycle wait.
- `HAZARD_CTRL_PERF_EN`: 1 load-use stall + 1 flush + one 3-cycle wait → `perf_stall_cnt=4`, `perf_flush_cnt=1`. `perf_clr` → both counters 0 on the next cycle.
